// File: rtl/bus_master_interface.sv
// System-bus initiator: accepts one core request at a time, runs a strobe/fc handshake on the
// shared bus, and returns read data or a timeout error as a single-cycle response pulse.
module bus_master_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    output logic        rd_bus,
    output logic        wr_bus,
    output logic [3:0]  data_mask_bus,
    input  logic        fc_bus
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRecover
    } state_e;

    state_e          state_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      mask_q;
    logic            rd_q;
    logic            wr_q;
    logic [CntW-1:0] cnt_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;
    logic [31:0]     byte_en;

    always_comb begin
        byte_en = '0;
        for (int i = 0; i < 4; i++) begin
            byte_en[8*i +: 8] = {8{mask_q[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        if (req_mask != 4'b0000) begin
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
                            mask_q  <= req_mask;
                            rd_q    <= !req_wr;
                            wr_q    <= req_wr;
                            cnt_q   <= '0;
                            state_q <= StAccess;
                        end else begin
                            // Empty byte mask: complete immediately without touching the bus.
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b0;
                        end
                    end
                end
                StAccess: begin
                    if (fc_bus) begin
                        rd_q         <= 1'b0;
                        wr_q         <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= rd_q ? (data_bus & byte_en) : 32'h0;
                        state_q      <= StRecover;
                    end else if (TimeoutEn && (cnt_q == CntLast)) begin
                        rd_q         <= 1'b0;
                        wr_q         <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state_q      <= StRecover;
                    end else if (cnt_q != {CntW{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRecover: begin
                    // A responder still holding fc must not complete the next transaction.
                    if (!fc_bus) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready     = (state_q == StIdle) && !resp_valid_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign addr_bus      = addr_q;
    assign data_mask_bus = mask_q;
    assign rd_bus        = rd_q;
    assign wr_bus        = wr_q;
    assign data_bus      = wr_q ? wdata_q : 32'hz;

    a_strobe_exclusive : assert property (@(posedge clk) disable iff (rst) !(rd_q && wr_q));
    a_resp_single      : assert property (@(posedge clk) disable iff (rst)
                                          resp_valid_q |=> !resp_valid_q);

endmodule

// File: tb/tb_bus_master_interface.sv
// Table-driven bench for bus_master_interface with a bus responder/keeper and a response scoreboard.
module tb_bus_master_interface;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus, wr_bus, fc_bus;
    logic [3:0]  data_mask_bus;

    logic        tb_drive, keeper_next;
    logic [31:0] tb_data;
    assign data_bus = tb_drive ? tb_data : 32'hz;

    always #5 clk = ~clk;

    bus_master_interface #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
        .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          delay;   // cycles of strobe before fc; negative = responder silent
        int          hold;    // extra cycles fc stays high after the strobe drops
        logic [31:0] rsp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    vec_t  vecs[9];
    int    checks = 0;
    int    failures = 0;
    logic  prev_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        resp_t e;
        @(posedge clk);
        tb_drive = keeper_next;
        #1;
        check("no_rd_wr_overlap", {31'd0, rd_bus & wr_bus}, 32'd0);
        if (resp_valid) begin
            check("resp_single_cycle", {31'd0, prev_rv}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none");
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
        prev_rv = resp_valid;
    endtask

    task automatic run_vec(input vec_t v);
        int    n;
        resp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_mask  = v.mask;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        sb.push_back(e);
        keeper_next = !(v.wr && v.mask != 4'b0000);
        tb_data     = 32'h0;
        tick();
        req_valid = 1'b0;
        if (v.mask == 4'b0000) begin
            check("mask0_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("mask0_ready_low", {31'd0, req_ready}, 32'd0);
            check("mask0_no_strobe", {30'd0, rd_bus, wr_bus}, 32'd0);
            tick();
            check("mask0_ready_back", {31'd0, req_ready}, 32'd1);
            check("mask0_no_strobe2", {30'd0, rd_bus, wr_bus}, 32'd0);
            return;
        end
        check("strobe_rise", {30'd0, rd_bus, wr_bus}, {30'd0, !v.wr, v.wr});
        check("addr_bus", addr_bus, v.addr);
        check("mask_bus", {28'd0, data_mask_bus}, {28'd0, v.mask});
        check("data_bus_first", data_bus, v.wr ? v.wdata : 32'h0);
        check("ready_low_access", {31'd0, req_ready}, 32'd0);
        if (v.delay < 0) begin
            n = 0;
            while ((rd_bus || wr_bus) && n < 40) begin
                n++;
                tick();
            end
            check("timeout_strobe_cycles", n, TO);
            check("timeout_resp_valid", {31'd0, resp_valid}, 32'd1);
            tick();
            check("ready_after_timeout", {31'd0, req_ready}, 32'd1);
        end else begin
            for (int i = 0; i < v.delay; i++) begin
                tick();
                check("strobe_held", {30'd0, rd_bus, wr_bus}, {30'd0, !v.wr, v.wr});
                check("data_held", data_bus, v.wr ? v.wdata : 32'h0);
                check("addr_held", addr_bus, v.addr);
            end
            fc_bus      = 1'b1;
            tb_data     = v.wr ? 32'h0 : v.rsp;
            keeper_next = 1'b1;
            tick();
            check("fc_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("strobe_dropped", {30'd0, rd_bus, wr_bus}, 32'd0);
            check("bus_released", data_bus, v.wr ? 32'h0 : v.rsp);
            tb_data = 32'h0;
            for (int i = 0; i < v.hold; i++) begin
                check("recover_ready_low", {31'd0, req_ready}, 32'd0);
                check("recover_no_strobe", {30'd0, rd_bus, wr_bus}, 32'd0);
                tick();
            end
            fc_bus = 1'b0;
            check("recover_ready_low_last", {31'd0, req_ready}, 32'd0);
            tick();
            check("ready_after_recover", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h7000_0000, 32'h0000_0001, 4'b1111, 3, 0, 32'h0,
                    32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h7000_0004, 32'h0, 4'b0011, 1, 0, 32'hDEAD_BEEF,
                    32'h0000_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h7000_0008, 32'h0, 4'b0000, 0, 0, 32'h0,
                    32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'h7000_000C, 32'h0, 4'b1111, -1, 0, 32'h0,
                    32'h0000_0000, 1'b1};
        vecs[4] = '{1'b1, 32'h7000_0010, 32'hA5A5_5A5A, 4'b0101, 0, 2, 32'h0,
                    32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 32'h7000_0014, 32'h1234_5678, 4'b1111, 0, 2, 32'h0,
                    32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, 32'h7000_0018, 32'h0, 4'b1100, 0, 1, 32'hCAFE_F00D,
                    32'hCAFE_0000, 1'b0};
        vecs[7] = '{1'b0, 32'h7000_001C, 32'h0, 4'b1001, 2, 0, 32'h1122_3344,
                    32'h1100_0044, 1'b0};
        vecs[8] = '{1'b1, 32'h7000_0020, 32'hFFFF_FFFF, 4'b0000, 0, 0, 32'h0,
                    32'h0000_0000, 1'b0};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_mask    = '0;
        fc_bus      = 1'b0;
        tb_data     = 32'h0;
        keeper_next = 1'b1;
        tb_drive    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rd_bus", {31'd0, rd_bus}, 32'd0);
        check("rst_wr_bus", {31'd0, wr_bus}, 32'd0);
        check("rst_addr_bus", addr_bus, 32'd0);
        check("rst_mask_bus", {28'd0, data_mask_bus}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_data_bus_free", data_bus, 32'd0);

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k]);
        end

        // Reset in the middle of a write access: no response, bus released, ready again.
        req_valid   = 1'b1;
        req_wr      = 1'b1;
        req_addr    = 32'h7000_0040;
        req_wdata   = 32'hFFFF_0000;
        req_mask    = 4'b1111;
        keeper_next = 1'b0;
        tick();
        req_valid = 1'b0;
        check("midrst_wr_up", {31'd0, wr_bus}, 32'd1);
        check("midrst_data", data_bus, 32'hFFFF_0000);
        tick();
        rst         = 1'b1;
        keeper_next = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_strobes", {30'd0, rd_bus, wr_bus}, 32'd0);
        check("midrst_data_free", data_bus, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        check("midrst_no_resp_later", {31'd0, resp_valid}, 32'd0);

        // Normal request after the reset abort.
        run_vec(vecs[7]);
        tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
